// File: rtl/mac_accumulator.sv
// Accumulates a stream of products into a running sum and presents each group's sum,
// sticky overflow flag and term count. Define MAC_SAT_EN to saturate on overflow.
module mac_accumulator #(
  parameter int unsigned length = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [length-1:0] in_data,
  input  logic              in_last,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [length-1:0] out_data,
  output logic              out_of,
  output logic [CNT_W-1:0]  out_cnt
);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e             state_q, state_d;
  logic [length-1:0]  acc_q, acc_d;
  logic               of_q, of_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [length-1:0]  out_data_q, out_data_d;
  logic               out_of_q, out_of_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

  logic               accept;
  logic [length-1:0]  base_acc;
  logic               base_of;
  logic [CNT_W-1:0]   base_cnt;
  logic [length:0]    sum;
  logic [length-1:0]  add_acc;
  logic               add_of;
  logic [CNT_W-1:0]   add_cnt;

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StHold);
  assign out_data  = out_data_q;
  assign out_of    = out_of_q;
  assign out_cnt   = out_cnt_q;
  assign accept    = in_valid && in_ready;

  // A clear coinciding with a beat makes that beat the first term of a new group.
  always_comb begin
    base_acc = clr ? '0 : acc_q;
    base_of  = clr ? 1'b0 : of_q;
    base_cnt = clr ? '0 : cnt_q;
    sum      = {1'b0, base_acc} + {1'b0, in_data};
`ifdef MAC_SAT_EN
    add_acc  = sum[length] ? '1 : sum[length-1:0];
`else
    add_acc  = sum[length-1:0];
`endif
    add_of   = base_of | sum[length];
    add_cnt  = (&base_cnt) ? base_cnt : base_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    of_d       = of_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_of_d   = out_of_q;
    out_cnt_d  = out_cnt_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          acc_d = add_acc;
          of_d  = add_of;
          cnt_d = add_cnt;
          if (in_last) begin
            out_data_d = add_acc;
            out_of_d   = add_of;
            out_cnt_d  = add_cnt;
            state_d    = StHold;
          end
        end else if (clr) begin
          acc_d = '0;
          of_d  = 1'b0;
          cnt_d = '0;
        end
      end
      // clr is deliberately ignored here so a pending result is never lost.
      StHold: begin
        if (out_ready) begin
          acc_d   = '0;
          of_d    = 1'b0;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAcc;
      acc_q      <= '0;
      of_q       <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_of_q   <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      of_q       <= of_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_of_q   <= out_of_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a 32-bit/8-bit-count instance and an 8-bit/2-bit-count
// instance share stimulus; results are checked against a sum-of-terms model.
module tb_mac_accumulator;

`ifdef MAC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 'x;
  logic        in_last = 'x;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_of;
  logic [31:0] a_out_data;
  logic [7:0]  a_out_cnt;
  logic        b_in_ready, b_out_valid, b_out_of;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_cnt;

  int checks = 0;
  int errors = 0;

  // Model: true (unbounded) totals and term count of the open group.
  longint unsigned tot_a, tot_b;
  int              n_terms;
  logic [63:0]     exp_a_data, exp_a_of, exp_a_cnt, exp_b_data, exp_b_of, exp_b_cnt;

  always #5 clk = ~clk;

  mac_accumulator #(.length(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .clr(clr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_of(a_out_of), .out_cnt(a_out_cnt)
  );

  mac_accumulator #(.length(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data[7:0]),
    .in_last(in_last), .clr(clr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_of(b_out_of), .out_cnt(b_out_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fold(input longint unsigned tot, input int w);
    longint unsigned top = 64'd1 << w;
    if (tot >= top) return Sat ? top - 1 : tot % top;
    return tot;
  endfunction

  function automatic logic [63:0] cnt_sat(input int n, input int w);
    int top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  task automatic model_clear();
    tot_a = 0; tot_b = 0; n_terms = 0;
  endtask

  task automatic model_accept(input logic [31:0] d, input logic last, input logic c);
    if (c) model_clear();
    tot_a += d;
    tot_b += d[7:0];
    n_terms++;
    if (last) begin
      exp_a_data = fold(tot_a, 32);
      exp_a_of   = (tot_a >= (64'd1 << 32));
      exp_a_cnt  = cnt_sat(n_terms, 8);
      exp_b_data = fold(tot_b, 8);
      exp_b_of   = (tot_b >= 64'd256);
      exp_b_cnt  = cnt_sat(n_terms, 2);
      model_clear();
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic c);
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_last = last; clr = c;
    while (!(a_in_ready && b_in_ready) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) check("send_ready_timeout", a_in_ready, 1'b1);
    @(posedge clk);
    model_accept(d, last, c);
    #1;
    in_valid = 1'b0; in_data = 'x; in_last = 'x; clr = 1'b0;
  endtask

  task automatic clear_only();
    logic was_acc;
    clr = 1'b1;
    was_acc = a_in_ready;
    @(posedge clk);
    if (was_acc) model_clear();
    #1 clr = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_a_data"}, a_out_data, exp_a_data);
    check({tag, "_a_of"}, a_out_of, exp_a_of);
    check({tag, "_a_cnt"}, a_out_cnt, exp_a_cnt);
    check({tag, "_b_data"}, b_out_data, exp_b_data);
    check({tag, "_b_of"}, b_out_of, exp_b_of);
    check({tag, "_b_cnt"}, b_out_cnt, exp_b_cnt);
  endtask

  // Waits for the result, holds it for `delay` cycles, then takes it.
  task automatic collect(input int delay, input logic clr_in_hold);
    int guard = 0;
    while (!a_out_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("out_valid_a", a_out_valid, 1'b1);
    check("out_valid_b", b_out_valid, 1'b1);
    for (int i = 0; i < delay; i++) begin
      check_result("hold");
      check("hold_in_ready", a_in_ready, 1'b0);
      check("hold_valid", a_out_valid, 1'b1);
      clr = clr_in_hold;
      @(posedge clk); #1;
    end
    clr = 1'b0;
    check_result("take");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("taken_valid", a_out_valid, 1'b0);
    check("taken_in_ready", a_in_ready, 1'b1);
  endtask

  initial begin
    model_clear();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_data", a_out_data, 32'd0);
    check("rst_of", a_out_of, 1'b0);
    check("rst_cnt", a_out_cnt, 8'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1;

    // Reset while a result is pending.
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b1, 1'b0);
    check("t1_pending", a_out_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("t1_rst_valid", a_out_valid, 1'b0);
    check("t1_rst_data", a_out_data, 32'd0);
    check("t1_rst_cnt", a_out_cnt, 8'd0);
    check("t1_rst_b_valid", b_out_valid, 1'b0);
    model_clear();
    @(negedge clk) rst = 1'b0;
    #1 check("t1_in_ready", a_in_ready, 1'b1);
    send(32'd5, 1'b1, 1'b0);
    check("t1_data", a_out_data, 32'd5);
    check("t1_cnt", a_out_cnt, 8'd1);
    collect(0, 1'b0);

    // Latency: result visible one cycle after the last beat.
    send(32'd6, 1'b0, 1'b0);
    send(32'd12, 1'b0, 1'b0);
    check("t2_not_yet", a_out_valid, 1'b0);
    send(32'd36, 1'b1, 1'b0);
    check("t2_valid", a_out_valid, 1'b1);
    check("t2_data", a_out_data, 32'd54);
    check("t2_of", a_out_of, 1'b0);
    check("t2_cnt", a_out_cnt, 8'd3);
    collect(0, 1'b0);

    // Overflow on the 8-bit instance.
    send(32'd200, 1'b0, 1'b0);
    send(32'd100, 1'b1, 1'b0);
    check("t3_b_data", b_out_data, Sat ? 8'd255 : 8'd44);
    check("t3_b_of", b_out_of, 1'b1);
    check("t3_b_cnt", b_out_cnt, 2'd2);
    check("t3_a_data", a_out_data, 32'd300);
    collect(1, 1'b1);

    // Backpressure: a waiting beat must not slip in during HOLD or the handshake.
    send(32'd3, 1'b0, 1'b0);
    send(32'd4, 1'b1, 1'b0);
    check("t4_data", a_out_data, 32'd7);
    in_valid = 1'b1; in_data = 32'd9; in_last = 1'b1;
    collect(5, 1'b1);
    send(32'd9, 1'b1, 1'b0);
    check("t4_next_data", a_out_data, 32'd9);
    check("t4_next_cnt", a_out_cnt, 8'd1);
    collect(0, 1'b0);

    // Clear coinciding with a beat.
    send(32'd20, 1'b0, 1'b0);
    send(32'd30, 1'b0, 1'b0);
    send(32'd7, 1'b0, 1'b1);
    send(32'd3, 1'b1, 1'b0);
    check("t5_data", a_out_data, 32'd10);
    check("t5_cnt", a_out_cnt, 8'd2);
    check("t5_of", a_out_of, 1'b0);
    collect(0, 1'b0);

    // Count saturation on the 2-bit counter.
    for (int i = 0; i < 5; i++) send(32'd1, i == 4, 1'b0);
    check("t6_b_data", b_out_data, 8'd5);
    check("t6_b_cnt", b_out_cnt, 2'd3);
    check("t6_a_cnt", a_out_cnt, 8'd5);
    collect(0, 1'b0);

    // Randomized groups with clears, idle cycles and backpressure.
    for (int g = 0; g < 20; g++) begin
      int len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        logic [31:0] d = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 300);
        if ($urandom_range(0, 5) == 0) clear_only();
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send(d, k == len - 1, $urandom_range(0, 7) == 0);
      end
      collect($urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    // Long group saturates the 8-bit counter.
    for (int i = 0; i < 260; i++) send($urandom_range(0, 15), i == 259, 1'b0);
    check("long_a_cnt", a_out_cnt, 8'd255);
    collect(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
